// File: rtl/alu_74181_seq_ctrl_if.sv
// Handshake and data bundle between an op issuer, the nibble-serial 74181 sequencer and a result consumer.
// The optional zero flag exists only when ALU_SEQ_ZERO_EN is defined.
interface alu_74181_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op_s;
  logic         op_m;
  logic         cin_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout_n;
  logic         a_eq_b;
`ifdef ALU_SEQ_ZERO_EN
  logic         zero;
`endif

  modport master (
    output in_valid, op_s, op_m, cin_n, a, b, out_ready,
    input  in_ready, out_valid, result, cout_n, a_eq_b
`ifdef ALU_SEQ_ZERO_EN
    , input zero
`endif
  );

  modport slave (
    input  in_valid, op_s, op_m, cin_n, a, b, out_ready,
    output in_ready, out_valid, result, cout_n, a_eq_b
`ifdef ALU_SEQ_ZERO_EN
    , output zero
`endif
  );
endinterface

// File: rtl/alu_74181_seq_ctrl.sv
// Nibble-serial sequencer running one 74181-style 4-bit slice over 4*NIBBLES-bit operands, LSB nibble first.
// Define ALU_SEQ_ZERO_EN to add a registered zero flag alongside the result.
module alu_74181_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_74181_seq_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   result_q;
  logic [3:0]     opS_q;
  logic           opM_q;
  logic           carry_q;
  logic           accEq_q;
  logic [CW-1:0]  cnt_q;
  logic           inReady_q;
  logic           outValid_q;
`ifdef ALU_SEQ_ZERO_EN
  logic           zero_q;
`endif

  logic [3:0]     aNib;
  logic [3:0]     bNib;
  logic [3:0]     pBits;
  logic [3:0]     gBits;
  logic [4:0]     sum;
  logic [3:0]     fNib;
  logic           sliceCoutN;
  logic           sliceEq;
  logic [W-1:0]   result_d;

  // The slice: per-bit propagate/generate from S, arithmetic F is P+G+carry, logic F is ~(P^G).
  always_comb begin
    aNib       = 4'(a_q >> (4 * cnt_q));
    bNib       = 4'(b_q >> (4 * cnt_q));
    pBits      = aNib | (bNib & {4{opS_q[0]}}) | (~bNib & {4{opS_q[1]}});
    gBits      = (aNib & ~bNib & {4{opS_q[2]}}) | (aNib & bNib & {4{opS_q[3]}});
    sum        = {1'b0, pBits} + {1'b0, gBits} + {4'b0, ~carry_q};
    fNib       = opM_q ? ~(pBits ^ gBits) : sum[3:0];
    sliceCoutN = ~sum[4];
    sliceEq    = &fNib;
    result_d   = (result_q & ~(W'(4'hF) << (4 * cnt_q))) | (W'(fNib) << (4 * cnt_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      opS_q      <= '0;
      opM_q      <= 1'b0;
      carry_q    <= 1'b1;
      accEq_q    <= 1'b0;
      cnt_q      <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            opS_q     <= bus.op_s;
            opM_q     <= bus.op_m;
            carry_q   <= bus.cin_n;
            cnt_q     <= '0;
            accEq_q   <= 1'b1;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= sliceCoutN;
          accEq_q  <= accEq_q & sliceEq;
          if (cnt_q == LAST) begin
            outValid_q <= 1'b1;
            state_q    <= DONE;
`ifdef ALU_SEQ_ZERO_EN
            zero_q     <= (result_d == '0);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Everything stays frozen until the consumer takes the result.
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.cout_n    = carry_q;
  assign bus.a_eq_b    = accEq_q;
`ifdef ALU_SEQ_ZERO_EN
  assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu_74181_seq_ctrl.sv
// Scoreboard bench for alu_74181_seq_ctrl: a driver pushes reference-model results, a monitor pops them on each result handshake.
// Zero-flag checks are included when ALU_SEQ_ZERO_EN is defined.
`timescale 1ns/1ps
module tb_alu_74181_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W  = 4 * NIBBLES;
  localparam int W1 = W + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         coutN;
    logic         chkCout;
    logic         eq;
    logic         zero;
    longint       acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  exp_t   expQ[$];
  int     total = 0;
  int     bad = 0;
  int     readyMode = 2;
  longint lastAccept = 0;

  always #5 clk = ~clk;

  alu_74181_seq_ctrl_if #(.NIBBLES(NIBBLES)) bif ();

  alu_74181_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 74181 function table: arithmetic rows as operand pairs summed with the carry, logic rows as plain boolean.
  function automatic void refModel(input logic [3:0] s, input logic m, input logic cinN,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] f, output logic coutN);
    logic [W-1:0] ones, x, y, lf;
    logic [W:0]   total1;
    ones = '1;
    case (s)
      4'h0: begin x = a;      y = '0;     lf = ~a;       end
      4'h1: begin x = a | b;  y = '0;     lf = ~(a | b); end
      4'h2: begin x = a | ~b; y = '0;     lf = ~a & b;   end
      4'h3: begin x = ones;   y = '0;     lf = '0;       end
      4'h4: begin x = a;      y = a & ~b; lf = ~(a & b); end
      4'h5: begin x = a | b;  y = a & ~b; lf = ~b;       end
      4'h6: begin x = a;      y = ~b;     lf = a ^ b;    end
      4'h7: begin x = a & ~b; y = ones;   lf = a & ~b;   end
      4'h8: begin x = a;      y = a & b;  lf = ~a | b;   end
      4'h9: begin x = a;      y = b;      lf = ~(a ^ b); end
      4'hA: begin x = a | ~b; y = a & b;  lf = b;        end
      4'hB: begin x = a & b;  y = ones;   lf = a & b;    end
      4'hC: begin x = a;      y = a;      lf = ones;     end
      4'hD: begin x = a | b;  y = a;      lf = a | ~b;   end
      4'hE: begin x = a | ~b; y = a;      lf = a | b;    end
      default: begin x = a;   y = ones;   lf = a;        end
    endcase
    total1 = {1'b0, x} + {1'b0, y} + W1'(!cinN);
    f      = m ? lf : total1[W-1:0];
    coutN  = !total1[W];
  endfunction

  // Presents one op, waits for in_ready, records the accept edge and pushes the expected response.
  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic cinN,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] f;
    logic         co;
    int           waited;
    @(negedge clk);
    bif.op_s = s; bif.op_m = m; bif.cin_n = cinN; bif.a = a; bif.b = b;
    bif.in_valid = 1'b1;
    waited = 0;
    while (!bif.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bif.in_ready) begin
      checkOutput("accept_timeout", 64'(0), 64'(1));
      bif.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lastAccept = longint'($time) / 10;
    refModel(s, m, cinN, a, b, f, co);
    e.res = f; e.coutN = co; e.chkCout = !m; e.eq = (f == '1); e.zero = (f == '0); e.acc = lastAccept;
    expQ.push_back(e);
    #1;
    bif.in_valid = 1'b0;
    bif.a = W'($urandom); bif.b = W'($urandom);
    bif.op_s = 4'($urandom); bif.op_m = 1'($urandom); bif.cin_n = 1'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while (expQ.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
  endtask

  // out_ready changes just after each rising edge so it is stable when the monitor samples.
  initial begin
    bif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       bif.out_ready = 1'($urandom_range(0, 1));
        1:       bif.out_ready = 1'b0;
        default: bif.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks latency on each out_valid rise and pops/compares on every result handshake.
  initial begin
    exp_t e;
    bit   prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bif.out_valid && !prevValid) begin
          if (expQ.size() == 0)
            checkOutput("unexpected_out_valid", 64'(1), 64'(0));
          else
            checkOutput("latency", 64'((longint'($time) / 10 - 1) - expQ[0].acc), 64'(NIBBLES));
        end
        if (bif.out_valid && bif.out_ready && expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("result", 64'(bif.result), 64'(e.res));
          if (e.chkCout) checkOutput("cout_n", 64'(bif.cout_n), 64'(e.coutN));
          checkOutput("a_eq_b", 64'(bif.a_eq_b), 64'(e.eq));
          checkOutput("in_ready_in_done", 64'(bif.in_ready), 64'(0));
`ifdef ALU_SEQ_ZERO_EN
          checkOutput("zero", 64'(bif.zero), 64'(e.zero));
`endif
        end
      end
      prevValid = bif.out_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [W-1:0] f;
    logic         co;
    longint       t1;
    int           waited;
    bit           sawValid;
    bif.in_valid = 1'b0; bif.op_s = '0; bif.op_m = 1'b0; bif.cin_n = 1'b1; bif.a = '0; bif.b = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",  64'(bif.in_ready),  64'(1));
    checkOutput("rst_out_valid", 64'(bif.out_valid), 64'(0));
    checkOutput("rst_result",    64'(bif.result),    64'(0));
    checkOutput("rst_cout_n",    64'(bif.cout_n),    64'(1));
    checkOutput("rst_a_eq_b",    64'(bif.a_eq_b),    64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321);
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    applyStimulus(4'b0110, 1'b0, 1'b0, 16'h5000, 16'h1000);
    applyStimulus(4'b0110, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
    applyStimulus(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    applyStimulus(4'b1011, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    drain();

    // Consumer stall: outputs must hold for ten cycles in DONE.
    readyMode = 1;
    repeat (2) @(negedge clk);
    applyStimulus(4'b1001, 1'b0, 1'b0, 16'h8421, 16'h1248);
    refModel(4'b1001, 1'b0, 1'b0, 16'h8421, 16'h1248, f, co);
    waited = 0;
    while (!bif.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_out_valid", 64'(bif.out_valid), 64'(1));
      checkOutput("stall_in_ready",  64'(bif.in_ready),  64'(0));
      checkOutput("stall_result",    64'(bif.result),    64'(f));
      checkOutput("stall_cout_n",    64'(bif.cout_n),    64'(co));
      @(negedge clk);
    end
    readyMode = 2;
    drain();

    // Back-to-back: second op is accepted NIBBLES+2 edges after the first.
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h00FF);
    t1 = lastAccept;
    applyStimulus(4'b0110, 1'b0, 1'b0, 16'h1000, 16'h0001);
    checkOutput("b2b_interval", 64'(lastAccept - t1), 64'(NIBBLES + 2));
    drain();

    // Reset during RUN at nibble 2: everything returns to reset values and no result appears.
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h7777, 16'h1111);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (expQ.size() != 0) void'(expQ.pop_back());
    checkOutput("midrst_out_valid", 64'(bif.out_valid), 64'(0));
    checkOutput("midrst_in_ready",  64'(bif.in_ready),  64'(1));
    checkOutput("midrst_result",    64'(bif.result),    64'(0));
    checkOutput("midrst_cout_n",    64'(bif.cout_n),    64'(1));
    checkOutput("midrst_a_eq_b",    64'(bif.a_eq_b),    64'(0));
`ifdef ALU_SEQ_ZERO_EN
    checkOutput("midrst_zero",      64'(bif.zero),      64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sawValid = sawValid | bif.out_valid;
    end
    checkOutput("midrst_no_valid", 64'(sawValid), 64'(0));
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321);
    drain();

    // Randomized ops with a randomly stalling consumer.
    readyMode = 0;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    readyMode = 2;
    drain();

`ifdef ALU_SEQ_ZERO_EN
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h0001, 16'hFFFF);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
